// File: rtl/reg_file_pkg.sv
// Shared types and default parameters for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/rf_clear_fsm.sv
// Bulk-clear sequencer: sweeps registers 1..DEPTH-1 to zero, one per cycle.
module rf_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  clr_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Register 0 is hardwired, so the sweep starts at 1; the pointer wraps to 0 on exit.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        ptr_next = ptr_reg + ADDR_W'(1);
        if (ptr_reg == '1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    sweep_we = 1'b0;
    if (state_reg == CLEAR) begin
      clr_busy = 1'b1;
      sweep_we = 1'b1;
    end
  end

  assign sweep_addr = ptr_reg;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired-zero r0 and a bulk-clear sweep.
// Define RF_BYPASS_EN for write-first read ports; default is read-first.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rf_ra,
  output logic [NUM_RD*DATA_W-1:0] rf_rd,
  input  logic                     rf_we,
  input  logic [ADDR_W-1:0]        rf_wa,
  input  logic [DATA_W-1:0]        rf_wd,
  output logic                     rf_wack,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [ADDR_W-1:0]        debug_reg_ra,
  output logic [DATA_W-1:0]        debug_reg_rd
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;

  rf_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we)
  );

  assign rf_wack = rf_we & ~clr_busy;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (rf_wack && (rf_wa != '0)) begin
      mem[rf_wa] <= rf_wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rf_ra[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      // Reset gating keeps the ports at zero even if a write is presented in reset.
      logic hit;
      assign hit = rf_wack & ~rst & (rf_wa != '0) & (ra == rf_wa);
      assign rf_rd[gi*DATA_W +: DATA_W] = (ra == '0) ? '0 : (hit ? rf_wd : mem[ra]);
`else
      assign rf_rd[gi*DATA_W +: DATA_W] = (ra == '0) ? '0 : mem[ra];
`endif
    end
  endgenerate

  assign debug_reg_rd = (debug_reg_ra == '0) ? '0 : mem[debug_reg_ra];

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised self-checking bench for reg_file_mp (4 ports x 64 bits).
module tb_reg_file_mp;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rf_ra;
  logic [NR*DW-1:0]  rf_rd;
  logic              rf_we;
  logic [AW-1:0]     rf_wa;
  logic [DW-1:0]     rf_wd;
  logic              rf_wack;
  logic              clr_req;
  logic              clr_busy;
  logic [AW-1:0]     debug_reg_ra;
  logic [DW-1:0]     debug_reg_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus "sweep in progress, next index to zero".
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy = 1'b0;
  int            m_next = 0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .NUM_RD(NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rf_ra       (rf_ra),
    .rf_rd       (rf_rd),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .rf_wack     (rf_wack),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .debug_reg_ra(debug_reg_ra),
    .debug_reg_rd(debug_reg_rd)
  );

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && !rst && rf_we && !m_busy && rf_wa == a) return rf_wd;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_dbg(input logic [AW-1:0] a);
    if (a == 0) return '0;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    m_busy = 1'b0;
    m_next = 0;
  endtask

  // Advance one rising edge and apply the edge's effect to the model.
  task automatic tick();
    logic acc;
    acc = rf_we && !m_busy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy) begin
        m_mem[m_next] = '0;
        m_next++;
        if (m_next == DEPTH) m_busy = 1'b0;
      end else if (clr_req) begin
        m_busy = 1'b1;
        m_next = 1;
      end
      if (acc && rf_wa != 0) m_mem[rf_wa] = rf_wd;
    end
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    rf_ra[p*AW +: AW] = a;
  endtask

  task automatic rand_ports();
    for (int p = 0; p < NR; p++) set_ra(p, AW'($urandom_range(0, DEPTH-1)));
    debug_reg_ra = AW'($urandom_range(0, DEPTH-1));
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_we = 1'b1; rf_wa = 5'd3; rf_wd = 64'h1234;
    clr_req = 1'b0; rf_ra = '0; set_ra(0, 5'd1); debug_reg_ra = 5'd1;
    model_reset();
    #2;
    n_checks++;
    if (rf_rd[0 +: DW] !== '0) begin n_fail++; $display("FAIL reset_rd0 got=%h exp=0", rf_rd[0 +: DW]); end
    n_checks++;
    if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    n_checks++;
    if (rf_wack !== 1'b1) begin n_fail++; $display("FAIL reset_wack got=%b exp=1", rf_wack); end
    n_checks++;
    if (debug_reg_rd !== '0) begin n_fail++; $display("FAIL reset_dbg got=%h exp=0", debug_reg_rd); end
    rf_we = 1'b0;
    #1;
    n_checks++;
    if (rf_wack !== 1'b0) begin n_fail++; $display("FAIL reset_wack_idle got=%b exp=0", rf_wack); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (rf_rd[0 +: DW] !== '0 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset rd0=%h busy=%b exp rd0=0 busy=0", rf_rd[0 +: DW], clr_busy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e;
    rf_we = 1'b1; rf_wa = 5'd1; rf_wd = 64'h1000_0000; set_ra(0, 5'd1);
    #1;
    e = BYPASS ? 64'h1000_0000 : 64'h0;
    n_checks++;
    if (rf_rd[0 +: DW] !== e) begin n_fail++; $display("FAIL same_cycle_rd got=%h exp=%h", rf_rd[0 +: DW], e); end
    n_checks++;
    if (rf_wack !== 1'b1) begin n_fail++; $display("FAIL wr1_wack got=%b exp=1", rf_wack); end
    tick();
    rf_we = 1'b0;
    #1;
    n_checks++;
    if (rf_rd[0 +: DW] !== 64'h1000_0000) begin
      n_fail++; $display("FAIL next_cycle_rd got=%h exp=10000000", rf_rd[0 +: DW]);
    end
    for (int it = 0; it < 24; it++) begin
      rf_we = 1'($urandom_range(0, 1));
      rf_wa = AW'($urandom_range(0, DEPTH-1));
      rf_wd = {$urandom, $urandom};
      rand_ports();
      if (it % 3 == 0) set_ra(1, rf_wa);
      #1;
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (rf_rd[p*DW +: DW] !== exp_rd(rf_ra[p*AW +: AW])) begin
          n_fail++; $display("FAIL rand_rd port%0d addr=%0d got=%h exp=%h", p, rf_ra[p*AW +: AW], rf_rd[p*DW +: DW], exp_rd(rf_ra[p*AW +: AW]));
        end
      end
      n_checks++;
      if (debug_reg_rd !== exp_dbg(debug_reg_ra)) begin
        n_fail++; $display("FAIL rand_dbg addr=%0d got=%h exp=%h", debug_reg_ra, debug_reg_rd, exp_dbg(debug_reg_ra));
      end
      tick();
    end
    rf_we = 1'b0;
    $display("test_write_read: done");
  endtask

  task automatic test_reg0();
    rf_we = 1'b1; rf_wa = 5'd0; rf_wd = 64'hDEAD_BEEF; set_ra(0, 5'd0); debug_reg_ra = 5'd0;
    #1;
    n_checks++;
    if (rf_wack !== 1'b1) begin n_fail++; $display("FAIL reg0_wack got=%b exp=1", rf_wack); end
    n_checks++;
    if (rf_rd[0 +: DW] !== '0) begin n_fail++; $display("FAIL reg0_bypass got=%h exp=0", rf_rd[0 +: DW]); end
    tick();
    rf_we = 1'b0;
    #1;
    n_checks++;
    if (rf_rd[0 +: DW] !== '0 || debug_reg_rd !== '0) begin
      n_fail++; $display("FAIL reg0_after rd=%h dbg=%h exp 0/0", rf_rd[0 +: DW], debug_reg_rd);
    end
    $display("test_reg0: done");
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int k = 1; k < DEPTH; k++) begin
      rf_we = 1'b1; rf_wa = AW'(k); rf_wd = DW'(k);
      tick();
    end
    // Write coinciding with the clear request must land, then be swept.
    rf_we = 1'b1; rf_wa = 5'd5; rf_wd = 64'hABC; clr_req = 1'b1;
    #1;
    n_checks++;
    if (rf_wack !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_start wack=%b busy=%b exp 1/0", rf_wack, clr_busy);
    end
    tick();
    rf_we = 1'b0; clr_req = 1'b0; debug_reg_ra = 5'd5;
    #1;
    n_checks++;
    if (debug_reg_rd !== 64'hABC) begin n_fail++; $display("FAIL coincide_wr got=%h exp=abc", debug_reg_rd); end
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      rf_we   = (c == 4);
      rf_wa   = AW'($urandom_range(1, DEPTH-1));
      rf_wd   = {$urandom, $urandom};
      clr_req = (c == 8);
      rand_ports();
      #1;
      n_checks++;
      if (clr_busy !== m_busy) begin n_fail++; $display("FAIL sweep_busy cyc=%0d got=%b exp=%b", c, clr_busy, m_busy); end
      n_checks++;
      if (rf_wack !== (rf_we && !m_busy)) begin
        n_fail++; $display("FAIL sweep_wack cyc=%0d got=%b exp=%b", c, rf_wack, rf_we && !m_busy);
      end
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (rf_rd[p*DW +: DW] !== exp_rd(rf_ra[p*AW +: AW])) begin
          n_fail++; $display("FAIL sweep_rd cyc=%0d port%0d got=%h exp=%h", c, p, rf_rd[p*DW +: DW], exp_rd(rf_ra[p*AW +: AW]));
        end
      end
      if (clr_busy) busy_cycles++;
      tick();
    end
    rf_we = 1'b0; clr_req = 1'b0;
    n_checks++;
    if (busy_cycles != DEPTH - 1) begin n_fail++; $display("FAIL busy_len got=%0d exp=%0d", busy_cycles, DEPTH - 1); end
    for (int k = 0; k < DEPTH; k++) begin
      debug_reg_ra = AW'(k); set_ra(2, AW'(k));
      #1;
      n_checks++;
      if (debug_reg_rd !== '0 || rf_rd[2*DW +: DW] !== '0) begin
        n_fail++; $display("FAIL after_clear reg%0d dbg=%h rd=%h exp 0", k, debug_reg_rd, rf_rd[2*DW +: DW]);
      end
    end
    $display("test_clear: done busy_cycles=%0d", busy_cycles);
  endtask

  task automatic test_reset_mid_sweep();
    for (int k = 1; k < DEPTH; k++) begin
      rf_we = 1'b1; rf_wa = AW'(k); rf_wd = {$urandom, $urandom} | 64'h1;
      tick();
    end
    rf_we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", clr_busy); end
    for (int k = 0; k < DEPTH; k++) begin
      debug_reg_ra = AW'(k);
      for (int p = 0; p < NR; p++) set_ra(p, AW'(k));
      #1;
      n_checks++;
      if (debug_reg_rd !== '0 || rf_rd[3*DW +: DW] !== '0) begin
        n_fail++; $display("FAIL midrst_reg%0d dbg=%h rd=%h exp 0", k, debug_reg_rd, rf_rd[3*DW +: DW]);
      end
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rf_we = 1'b1; rf_wa = 5'd20; rf_wd = 64'h5;
    tick();
    rf_we = 1'b0; set_ra(0, 5'd20); debug_reg_ra = 5'd20;
    for (int c = 0; c < 40; c++) begin
      #1;
      n_checks++;
      if (rf_rd[0 +: DW] !== 64'h5 || debug_reg_rd !== 64'h5 || clr_busy !== 1'b0) begin
        n_fail++; $display("FAIL no_resume cyc=%0d rd=%h dbg=%h busy=%b exp 5/5/0", c, rf_rd[0 +: DW], debug_reg_rd, clr_busy);
      end
      tick();
    end
    $display("test_reset_mid_sweep: done");
  endtask

  task automatic test_multiport();
    logic [AW-1:0] a [NR];
    logic [DW-1:0] v [NR];
    int base;
    base = $urandom_range(0, DEPTH-2);
    for (int i = 0; i < NR; i++) begin
      a[i] = AW'(1 + ((base + i*7) % (DEPTH-1)));
      v[i] = {$urandom, $urandom};
      rf_we = 1'b1; rf_wa = a[i]; rf_wd = v[i];
      tick();
    end
    rf_we = 1'b0;
    for (int p = 0; p < NR; p++) set_ra(p, a[NR-1-p]);
    #1;
    for (int p = 0; p < NR; p++) begin
      n_checks++;
      if (rf_rd[p*DW +: DW] !== v[NR-1-p]) begin
        n_fail++; $display("FAIL multiport port%0d addr=%0d got=%h exp=%h", p, a[NR-1-p], rf_rd[p*DW +: DW], v[NR-1-p]);
      end
    end
    $display("test_multiport: done");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] prev_wa;
    prev_wa = '0;
    for (int c = 0; c < 20; c++) begin
      rf_we = 1'b1;
      rf_wa = AW'($urandom_range(0, DEPTH-1));
      rf_wd = {$urandom, $urandom};
      set_ra(0, prev_wa); set_ra(1, rf_wa);
      set_ra(2, AW'($urandom_range(0, DEPTH-1))); set_ra(3, AW'($urandom_range(0, DEPTH-1)));
      #1;
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (rf_rd[p*DW +: DW] !== exp_rd(rf_ra[p*AW +: AW])) begin
          n_fail++; $display("FAIL b2b cyc=%0d port%0d got=%h exp=%h", c, p, rf_rd[p*DW +: DW], exp_rd(rf_ra[p*AW +: AW]));
        end
      end
      prev_wa = rf_wa;
      tick();
    end
    rf_we = 1'b0;
    $display("test_back_to_back: done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_reg0();
    test_clear();
    test_reset_mid_sweep();
    test_multiport();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
